shift_seq_ctrl: RTL

- Multi-cycle shift sequencer for the 8-bit datapath; used for mantissa alignment and normalisation (for example, right-shifting the mantissa by an exponent difference).
- Latches an operand, shift amount and mode on Start, then shifts one bit position per clock, then raises Done.
- Sits between the core's control unit and the register file write-back path, replacing a combinational barrel shifter to save area.
- Handshake is Start/Done, level style, matching the Top-level convention.

---
 rtl/shift_seq_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_seq_ctrl : serial 1-bit-per-clock shifter with Start/Done handshake,
//                  carry and sticky tracking.   rev 1.0
// ---------------------------------------------------------------------------
module shift_seq_ctrl #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Dir,
  input  logic          Arith,
  input  logic [CW-1:0] Amount,
  input  logic [W-1:0]  DataIn,
  output logic [W-1:0]  DataOut,
  output logic          Carry,
  output logic          Sticky,
  output logic          Busy,
  output logic          Done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [W-1:0]  data_q,   data_d;
  logic          carry_q,  carry_d;
  logic          sticky_q, sticky_d;
  logic          dir_q,    dir_d;
  logic          arith_q,  arith_d;

  logic          shift_bit;
  logic [W-1:0]  shift_val;

  // Single-position step of the working register in the latched direction
  always_comb begin
    shift_bit = 1'b0;
    shift_val = data_q;
    if (dir_q) begin
      shift_bit = data_q[W-1];
      shift_val = {data_q[W-2:0], 1'b0};
    end else begin
      shift_bit = data_q[0];
      shift_val = {(arith_q ? data_q[W-1] : 1'b0), data_q[W-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    carry_d  = carry_q;
    sticky_d = sticky_q;
    dir_d    = dir_q;
    arith_d  = arith_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          data_d   = DataIn;
          dir_d    = Dir;
          arith_d  = Arith;
          cnt_d    = Amount;
          carry_d  = 1'b0;
          sticky_d = 1'b0;
          state_d  = (Amount != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        data_d   = shift_val;
        carry_d  = shift_bit;
        sticky_d = sticky_q | shift_bit;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      carry_q  <= 1'b0;
      sticky_q <= 1'b0;
      dir_q    <= 1'b0;
      arith_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      carry_q  <= carry_d;
      sticky_q <= sticky_d;
      dir_q    <= dir_d;
      arith_q  <= arith_d;
    end
  end

  assign DataOut = data_q;
  assign Carry   = carry_q;
  assign Sticky  = sticky_q;
  assign Busy    = (state_q == S_SHIFT);
  assign Done    = (state_q == S_DONE);

endmodule
`default_nettype wire
